serial_add_ctrl: RTL and testbench

- Multi-cycle WIDTH-bit add/subtract unit built around one 4-bit carry-select adder slice (adder_4bits_block).
- Walks the operands one nibble per clock, LSB nibble first, and keeps the running carry in a register.
- Start/done handshake; serves as a small shared-adder ALU helper in the RISC-V datapath.

---
 rtl/serial_add_ctrl.sv | 156 +++++++++++++++
 tb/tb_serial_add_ctrl.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// Multi-cycle add/subtract: one 4-bit carry-select slice walked LSB nibble first.
// Optional early termination on zero upper nibbles: define SERIAL_ADD_EARLY_EXIT_EN.

module adder_4bits_block (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       ci,
   output logic [3:0] sum,
   output logic       co,
   output logic       c3
);
   logic [4:0] sum0, sum1;
   logic [3:0] low0, low1;

   // Both carry-in cases are computed in parallel, then selected by ci.
   always_comb begin
      sum0 = 5'(a) + 5'(b);
      sum1 = 5'(a) + 5'(b) + 5'(1);
      low0 = 4'(a[2:0]) + 4'(b[2:0]);
      low1 = 4'(a[2:0]) + 4'(b[2:0]) + 4'(1);
      sum  = ci ? sum1[3:0] : sum0[3:0];
      co   = ci ? sum1[4]   : sum0[4];
      c3   = ci ? low1[3]   : low0[3];
   end
endmodule

module serial_add_ctrl #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] s,
   output logic             co,
   output logic             ovf
);
   localparam int unsigned N     = WIDTH / 4;
   localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;

   if ((WIDTH % 4) != 0 || WIDTH < 8) begin : g_width_check
      $error("serial_add_ctrl: WIDTH must be a multiple of 4 and >= 8");
   end

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] opa, opb, opa_nxt, opb_nxt, s_nxt;
   logic             carry, carry_nxt;
   logic [IDX_W-1:0] idx, idx_nxt;
   logic             co_nxt, ovf_nxt, busy_nxt, done_nxt;
   logic [3:0]       sl_a, sl_b, sl_sum;
   logic             sl_co, sl_c3;
   logic             last_slice, early_exit;

   assign sl_a       = opa[{idx, 2'b00} +: 4];
   assign sl_b       = opb[{idx, 2'b00} +: 4];
   assign last_slice = (idx == IDX_W'(N - 1));

   adder_4bits_block u_slice (
      .a   (sl_a),
      .b   (sl_b),
      .ci  (carry),
      .sum (sl_sum),
      .co  (sl_co),
      .c3  (sl_c3)
   );

`ifdef SERIAL_ADD_EARLY_EXIT_EN
   logic [WIDTH-1:0] rem;
   // Nothing left to add once the carry dies and all higher operand nibbles are zero.
   assign rem        = (opa | opb) >> {idx, 2'b00};
   assign early_exit = !last_slice && !sl_co && (rem[WIDTH-1:4] == '0);
`else
   assign early_exit = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = RUN;
         RUN:     if (last_slice || early_exit) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      opa_nxt   = opa;
      opb_nxt   = opb;
      carry_nxt = carry;
      idx_nxt   = idx;
      s_nxt     = s;
      co_nxt    = co;
      ovf_nxt   = ovf;
      busy_nxt  = (state_nxt != IDLE);
      done_nxt  = (state_nxt == DONE);
      case (state)
         IDLE: begin
            if (start) begin
               opa_nxt   = a;
               opb_nxt   = sub ? ~b : b;
               carry_nxt = sub;
               idx_nxt   = '0;
               s_nxt     = '0;
            end
         end
         RUN: begin
            s_nxt[{idx, 2'b00} +: 4] = sl_sum;
            carry_nxt = sl_co;
            idx_nxt   = idx + IDX_W'(1);
            if (last_slice) begin
               co_nxt  = sl_co;
               ovf_nxt = sl_c3 ^ sl_co;
            end else if (early_exit) begin
               co_nxt  = 1'b0;
               ovf_nxt = 1'b0;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         opa   <= '0;
         opb   <= '0;
         carry <= 1'b0;
         idx   <= '0;
         s     <= '0;
         co    <= 1'b0;
         ovf   <= 1'b0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         opa   <= opa_nxt;
         opb   <= opb_nxt;
         carry <= carry_nxt;
         idx   <= idx_nxt;
         s     <= s_nxt;
         co    <= co_nxt;
         ovf   <= ovf_nxt;
         busy  <= busy_nxt;
         done  <= done_nxt;
      end
   end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl against an arithmetic reference model.
`timescale 1ns/1ps

module tb_serial_add_ctrl;
   localparam int unsigned WIDTH = 32;
   localparam int unsigned N     = WIDTH / 4;
   localparam int          MAX_WAIT = 40;

   logic             clk = 1'b0;
   logic             rst_n, start, sub;
   logic [WIDTH-1:0] a, b, s;
   logic             busy, done, co, ovf;

   int checks = 0;
   int errors = 0;

   serial_add_ctrl #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .sub   (sub),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .done  (done),
      .s     (s),
      .co    (co),
      .ovf   (ovf)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference: plain two's complement arithmetic.
   function automatic logic [WIDTH+1:0] model(input logic [WIDTH-1:0] ra, input logic [WIDTH-1:0] rb,
                                              input logic rsub);
      logic [WIDTH:0]   full;
      logic [WIDTH-1:0] eff_b;
      logic             v;
      eff_b = rsub ? (~rb + WIDTH'(1)) : rb;
      full  = {1'b0, ra} + {1'b0, (rsub ? ~rb : rb)} + (WIDTH+1)'(rsub);
      v     = (ra[WIDTH-1] == eff_b[WIDTH-1]) && (full[WIDTH-1] != ra[WIDTH-1]);
      if (rsub) v = (ra[WIDTH-1] != rb[WIDTH-1]) && (full[WIDTH-1] != ra[WIDTH-1]);
      return {v, full};
   endfunction

   // Expected number of compute edges.
   function automatic int exp_lat(input logic [WIDTH-1:0] ra, input logic [WIDTH-1:0] rb,
                                  input logic rsub);
      int lat = N;
`ifdef SERIAL_ADD_EARLY_EXIT_EN
      logic [63:0] ea, eb, mask, part;
      ea = 64'(ra);
      eb = rsub ? 64'(~rb) : 64'(rb);
      for (int i = 0; i < N - 1; i++) begin
         mask = (64'd1 << (4 * (i + 1))) - 64'd1;
         part = (ea & mask) + (eb & mask) + 64'(rsub);
         if (part[4 * (i + 1)] == 1'b0 && ((ea | eb) >> (4 * (i + 1))) == 64'd0) begin
            lat = i + 1;
            break;
         end
      end
`endif
      return lat;
   endfunction

   task automatic run_op(input string tag, input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v,
                         input logic tsub);
      logic [WIDTH+1:0] m;
      logic [WIDTH-1:0] s_done;
      int               cyc;
      m = model(ta, tb_v, tsub);
      @(posedge clk); #1;
      start = 1'b1; a = ta; b = tb_v; sub = tsub;
      @(posedge clk); #1;
      start = 1'b0; a = $urandom; b = $urandom; sub = 1'($urandom);
      check({tag, ".busy_start"}, 64'(busy), 64'd1);
      cyc = 0;
      while (!done && cyc < MAX_WAIT) begin
         @(posedge clk); #1;
         cyc++;
      end
      check({tag, ".latency"}, 64'(cyc), 64'(exp_lat(ta, tb_v, tsub)));
      check({tag, ".s"}, 64'(s), 64'(m[WIDTH-1:0]));
      check({tag, ".co_ovf"}, 64'({co, ovf}), 64'({m[WIDTH], m[WIDTH+1]}));
      s_done = s;
      @(posedge clk); #1;
      check({tag, ".idle_hold"}, 64'({busy, done, s}), 64'({2'b00, s_done}));
   endtask

   initial begin
      logic [WIDTH-1:0] ra, rb;
      int               accepts, lat1;
      logic             prev;

      rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset", 64'({busy, done, co, ovf, s}), 64'd0);
      rst_n = 1'b1;

      // Reset mid-RUN
      @(posedge clk); #1;
      start = 1'b1; a = 32'h0000_00FF; b = 32'h0000_0001; sub = 1'b0;
      @(posedge clk); #1;            // E0
      start = 1'b0;
      @(posedge clk); #1;            // E1
      @(posedge clk); #1;            // E2
      rst_n = 1'b0;
      @(posedge clk); #1;            // E3 (reset)
      check("midrun_reset", 64'({busy, done, s}), 64'd0);
      rst_n = 1'b1;
      run_op("after_reset", 32'h0000_00FF, 32'h0000_0001, 1'b0);

      run_op("basic_add", 32'h1234_5678, 32'h1111_1111, 1'b0);
      run_op("ripple",    32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
      run_op("sub_ovf",   32'h8000_0000, 32'h0000_0001, 1'b1);
      run_op("sub_neg",   32'h0000_0003, 32'h0000_0005, 1'b1);
      run_op("small",     32'h0000_0005, 32'h0000_0003, 1'b0);
      run_op("pos_ovf",   32'h7FFF_FFFF, 32'h0000_0001, 1'b0);

      // Busy rejection: start held high for 12 edges
      lat1 = exp_lat(32'd1, 32'd2, 1'b0);
      accepts = 0;
      @(posedge clk); #1;
      start = 1'b1; a = 32'd1; b = 32'd2; sub = 1'b0;
      for (int i = 0; i < 12; i++) begin
         prev = busy;
         @(posedge clk); #1;
         if (!prev && busy) accepts++;
         if (done) check("hold_start.s", 64'(s), 64'd3);
      end
      start = 1'b0;
      check("hold_start.accepts", 64'(accepts), 64'((12 + lat1 + 1) / (lat1 + 2)));
      for (int i = 0; i < MAX_WAIT && busy; i++) begin
         @(posedge clk); #1;
      end
      check("hold_start.final", 64'({busy, s}), 64'({1'b0, 32'd3}));

      // Randomized operations, biased toward small operands
      for (int i = 0; i < 30; i++) begin
         ra = $urandom; rb = $urandom;
         if ($urandom_range(0, 3) == 0) begin
            ra = ra & 32'h0000_00FF;
            rb = rb & 32'h0000_00FF;
         end
         run_op($sformatf("rand%0d", i), ra, rb, 1'($urandom));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
